speedpong_io_frontend: RTL and testbench

//  Parametrised board-I/O front end for SpeedPong on the DE2-115. It conditions
//  N_CH raw GPIO paddle buttons (2-flop sync, debounce, press pulse). It keeps a
//  2-digit BCD score per player, detects the win condition and drives active-low
//  HEX digits. It sits between the board pins and the game core, and replaces

---
 rtl/speedpong_io_pkg.sv | 22 ++
 rtl/speedpong_btn_cond.sv | 51 +++++
 rtl/speedpong_io_frontend.sv | 124 ++++++++++++
 tb/tb_speedpong_io_frontend.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/speedpong_io_pkg.sv
// Shared types, 7-segment table and BCD increment for the SpeedPong board I/O front end.
package speedpong_io_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [7:0] bcd2_t;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic bcd2_t bcd_inc(input bcd2_t v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/speedpong_btn_cond.sv
// One button channel: polarity correction, 2-flop synchroniser, debounce counter and
// registered press pulse on the debounced 0->1 edge.
module speedpong_btn_cond
    import speedpong_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pin;
    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    assign pin = raw ^ BTN_ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            // synchroniser stages
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
            // debounce stage: any bounce back to the accepted level restarts the count
            press   <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_p1;
                press <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/speedpong_io_frontend.sv
// SpeedPong board I/O front end: button conditioning, per-player BCD scores, win detect, HEX drive.
// Optional winner-digit flashing is enabled by defining WIN_FLASH_EN.
module speedpong_io_frontend
    import speedpong_io_pkg::*;
#(
    parameter int    N_CH            = 4,
    parameter int    N_PLAYERS       = 2,
    parameter int    DEBOUNCE_CYCLES = 500_000,
    parameter bit    BTN_ACTIVE_LOW  = 1'b0,
    parameter bcd2_t WIN_SCORE       = 8'h11,
    parameter int    FLASH_CYCLES    = 12_500_000
) (
    input  logic                                             CLOCK_50,
    input  logic                                             reset,
    input  logic [N_CH-1:0]                                  btn_raw,
    input  logic [N_PLAYERS-1:0]                             point,
    input  logic                                             clear_scores,
    output logic [N_CH-1:0]                                  btn_level,
    output logic [N_CH-1:0]                                  btn_press,
    output logic [8*N_PLAYERS-1:0]                           score,
    output logic [14*N_PLAYERS-1:0]                          hex,
    output logic                                             game_over,
    output logic [((N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1)-1:0] winner
);

    localparam int WIN_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_btn
        speedpong_btn_cond #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_btn (
            .clk   (CLOCK_50),
            .reset (reset),
            .raw   (btn_raw[ch]),
            .level (btn_level[ch]),
            .press (btn_press[ch])
        );
    end

    logic [8*N_PLAYERS-1:0] score_nxt;
    logic                   go_nxt;
    logic [WIN_W-1:0]       win_nxt;

    // Win is judged on the next-state scores; descending scan leaves the lowest index.
    always_comb begin
        score_nxt = score;
        go_nxt    = game_over;
        win_nxt   = winner;
        if (clear_scores) begin
            score_nxt = '0;
            go_nxt    = 1'b0;
            win_nxt   = '0;
        end else if (!game_over) begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (point[i])
                    score_nxt[8*i +: 8] = bcd_inc(score[8*i +: 8]);
            end
            for (int i = N_PLAYERS - 1; i >= 0; i--) begin
                if (score_nxt[8*i +: 8] == WIN_SCORE) begin
                    go_nxt  = 1'b1;
                    win_nxt = WIN_W'(i);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            score     <= '0;
            game_over <= 1'b0;
            winner    <= '0;
        end else begin
            score     <= score_nxt;
            game_over <= go_nxt;
            winner    <= win_nxt;
        end
    end

    logic blank_winner;

`ifdef WIN_FLASH_EN
    localparam int FL_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

    logic [FL_W-1:0] flash_cnt;
    logic            flash_on;

    // Held at zero / on phase until the win, so the first on phase is a full period.
    always_ff @(posedge CLOCK_50) begin
        if (reset || !game_over) begin
            flash_cnt <= '0;
            flash_on  <= 1'b1;
        end else if (flash_cnt == FL_W'(FLASH_CYCLES - 1)) begin
            flash_cnt <= '0;
            flash_on  <= !flash_on;
        end else begin
            flash_cnt <= flash_cnt + 1'b1;
        end
    end

    assign blank_winner = game_over && !flash_on;
`else
    logic unused_flash;
    assign unused_flash = (FLASH_CYCLES > 0);
    assign blank_winner = 1'b0;
`endif

    function automatic seg7_t seg_decode(input logic [3:0] n);
        if (n <= 4'd9)
            return SEG_DIGIT[n];
        return SEG_BLANK;
    endfunction

    always_comb begin
        hex = '1;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (!(blank_winner && (winner == WIN_W'(i)))) begin
                hex[14*i +: 7]     = seg_decode(score[8*i +: 4]);
                hex[14*i + 7 +: 7] = seg_decode(score[8*i + 4 +: 4]);
            end
        end
    end

endmodule

// File: tb/tb_speedpong_io_frontend.sv
// Directed bench for speedpong_io_frontend (DEBOUNCE_CYCLES=4, WIN_SCORE=8'h11, FLASH_CYCLES=8).
module tb_speedpong_io_frontend;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  btn_raw;
    logic [1:0]  point;
    logic        clear_scores;
    logic [3:0]  btn_level;
    logic [3:0]  btn_press;
    logic [15:0] score;
    logic [27:0] hex;
    logic        game_over;
    logic [0:0]  winner;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S9 = 7'b0010000;

    speedpong_io_frontend #(
        .N_CH            (4),
        .N_PLAYERS       (2),
        .DEBOUNCE_CYCLES (4),
        .BTN_ACTIVE_LOW  (1'b0),
        .WIN_SCORE       (8'h11),
        .FLASH_CYCLES    (8)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .point        (point),
        .clear_scores (clear_scores),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .score        (score),
        .hex          (hex),
        .game_over    (game_over),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [27:0] exp_hex;
        exp_hex = {4{S0}};
        reset = 1'b1; btn_raw = '0; point = '0; clear_scores = 1'b0;
        repeat (3) tick();
        total++; if (hex !== exp_hex) begin bad++; $display("FAIL reset_hex: got %h expected %h", hex, exp_hex); end
        total++; if (btn_level !== 4'h0) begin bad++; $display("FAIL reset_level: got %h expected 0", btn_level); end
        total++; if (btn_press !== 4'h0) begin bad++; $display("FAIL reset_press: got %h expected 0", btn_press); end
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
        total++; if (score !== 16'h0000) begin bad++; $display("FAIL reset_score: got %h expected 0000", score); end
        total++; if (winner !== 1'b0) begin bad++; $display("FAIL reset_winner: got %b expected 0", winner); end
        reset = 1'b0;
        tick();
    endtask

    // Bounces for cycles 0..9, then steady high from t=10: press expected at cycle 16.
    task automatic test_debounce();
        int cyc = 0;
        int presses = 0;
        int press_cyc = -1;
        int level_cyc = -1;
        for (int c = 0; c < 25; c++) begin
            btn_raw[0] = (c >= 10) ? 1'b1 : (((c / 2) % 2) == 1);
            tick();
            cyc++;
            if (btn_press[0]) begin presses++; if (press_cyc < 0) press_cyc = cyc; end
            if (btn_level[0] && level_cyc < 0) level_cyc = cyc;
        end
        total++; if (presses !== 1) begin bad++; $display("FAIL debounce_press_count: got %0d expected 1", presses); end
        total++; if (press_cyc !== 16) begin bad++; $display("FAIL debounce_press_cycle: got %0d expected 16", press_cyc); end
        total++; if (level_cyc !== 16) begin bad++; $display("FAIL debounce_level_cycle: got %0d expected 16", level_cyc); end
        total++; if (btn_level[0] !== 1'b1) begin bad++; $display("FAIL debounce_level_hold: got %b expected 1", btn_level[0]); end
    endtask

    task automatic test_release();
        int presses = 0;
        btn_raw[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (btn_press[0]) presses++;
        end
        total++; if (presses !== 0) begin bad++; $display("FAIL release_press_count: got %0d expected 0", presses); end
        total++; if (btn_level[0] !== 1'b0) begin bad++; $display("FAIL release_level: got %b expected 0", btn_level[0]); end
    endtask

    task automatic test_score();
        point = 2'b01;
        repeat (9) tick();
        total++; if (score[7:0] !== 8'h09) begin bad++; $display("FAIL score_nine: got %h expected 09", score[7:0]); end
        total++; if (hex[6:0] !== S9) begin bad++; $display("FAIL hex_units_nine: got %b expected %b", hex[6:0], S9); end
        tick();
        point = 2'b00;
        total++; if (score[7:0] !== 8'h10) begin bad++; $display("FAIL score_ten: got %h expected 10", score[7:0]); end
        total++; if (hex[13:7] !== S1) begin bad++; $display("FAIL hex_tens_ten: got %b expected %b", hex[13:7], S1); end
        total++; if (hex[6:0] !== S0) begin bad++; $display("FAIL hex_units_ten: got %b expected %b", hex[6:0], S0); end
        total++; if (score[15:8] !== 8'h00) begin bad++; $display("FAIL score_p1_idle: got %h expected 00", score[15:8]); end
    endtask

    task automatic test_simultaneous_win();
        point = 2'b10;
        repeat (10) tick();
        total++; if (score !== 16'h1010) begin bad++; $display("FAIL score_both_ten: got %h expected 1010", score); end
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL premature_game_over: got %b expected 0", game_over); end
        point = 2'b11;
        tick();
        point = 2'b00;
        total++; if (score !== 16'h1111) begin bad++; $display("FAIL score_both_win: got %h expected 1111", score); end
        total++; if (game_over !== 1'b1) begin bad++; $display("FAIL win_game_over: got %b expected 1", game_over); end
        total++; if (winner !== 1'b0) begin bad++; $display("FAIL win_lowest_index: got %b expected 0", winner); end
        point = 2'b11;
        repeat (3) tick();
        point = 2'b00;
        total++; if (score !== 16'h1111) begin bad++; $display("FAIL score_frozen: got %h expected 1111", score); end
        total++; if (game_over !== 1'b1) begin bad++; $display("FAIL game_over_hold: got %b expected 1", game_over); end
    endtask

    task automatic test_clear_and_pending_reset();
        int presses = 0;
        logic [27:0] exp_hex;
        exp_hex = {4{S0}};
        clear_scores = 1'b1; point = 2'b10;
        tick();
        clear_scores = 1'b0; point = 2'b00;
        total++; if (score !== 16'h0000) begin bad++; $display("FAIL clear_score: got %h expected 0000", score); end
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL clear_game_over: got %b expected 0", game_over); end
        total++; if (winner !== 1'b0) begin bad++; $display("FAIL clear_winner: got %b expected 0", winner); end
        total++; if (hex !== exp_hex) begin bad++; $display("FAIL clear_hex: got %h expected %h", hex, exp_hex); end
        // Four edges after the press the debounce count sits at 2 of 4.
        btn_raw[1] = 1'b1;
        repeat (4) begin tick(); if (btn_press[1]) presses++; end
        btn_raw[1] = 1'b0;
        reset = 1'b1;
        repeat (2) begin tick(); if (btn_press[1]) presses++; end
        reset = 1'b0;
        repeat (8) begin tick(); if (btn_press[1]) presses++; end
        total++; if (presses !== 0) begin bad++; $display("FAIL pending_press: got %0d expected 0", presses); end
        total++; if (btn_level[1] !== 1'b0) begin bad++; $display("FAIL pending_level: got %b expected 0", btn_level[1]); end
    endtask

`ifdef WIN_FLASH_EN
    task automatic test_flash();
        logic [13:0] on_digits;
        logic [13:0] p0_digits;
        logic [13:0] exp_p1;
        on_digits = {S1, S1};
        p0_digits = {S0, S0};
        clear_scores = 1'b1;
        tick();
        clear_scores = 1'b0;
        point = 2'b10;
        repeat (11) tick();
        point = 2'b00;
        total++; if (game_over !== 1'b1) begin bad++; $display("FAIL flash_game_over: got %b expected 1", game_over); end
        total++; if (winner !== 1'b1) begin bad++; $display("FAIL flash_winner: got %b expected 1", winner); end
        for (int k = 0; k < 24; k++) begin
            exp_p1 = (((k / 8) % 2) == 0) ? on_digits : 14'h3FFF;
            total++; if (hex[27:14] !== exp_p1) begin bad++; $display("FAIL flash_p1_k%0d: got %h expected %h", k, hex[27:14], exp_p1); end
            total++; if (hex[13:0] !== p0_digits) begin bad++; $display("FAIL flash_p0_k%0d: got %h expected %h", k, hex[13:0], p0_digits); end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_debounce();
        test_release();
        test_score();
        test_simultaneous_win();
        test_clear_and_pending_reset();
`ifdef WIN_FLASH_EN
        test_flash();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
